// File: rtl/pool_lin_sender_pkg.sv
// Shared constants, snapshot entry layout and serializer state encoding for
// the pooled-line sender.
package pool_lin_sender_pkg;

  localparam int POOL_CH       = 3;
  localparam int POOL_ELEM     = 3;
  localparam int POOL_BYTES    = 9;
  localparam int CNT_MAX       = 68;
  localparam int BYTE_W        = 8;
  localparam int ENTRY_W       = POOL_CH * POOL_ELEM * BYTE_W;
  localparam int TAG_W         = 2;
  localparam int IDX_W         = 4;
  localparam int SNAP_W        = ENTRY_W + TAG_W;

  localparam int CNT_W_DEF     = 7;
  localparam int CAP0_DEF      = 35;
  localparam int CAP1_DEF      = 51;
  localparam int CAP2_DEF      = 67;
  localparam int BUF_DEPTH_DEF = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [ENTRY_W-1:0] data;
  } snap_t;

  // Byte k of {D3,D2,D1}: D1 low byte first, D3 high byte last.
  function automatic logic [BYTE_W-1:0] entry_byte(input logic [ENTRY_W-1:0] e,
                                                   input logic [IDX_W-1:0]   idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      4'd0:    b = e[7:0];
      4'd1:    b = e[15:8];
      4'd2:    b = e[23:16];
      4'd3:    b = e[31:24];
      4'd4:    b = e[39:32];
      4'd5:    b = e[47:40];
      4'd6:    b = e[55:48];
      4'd7:    b = e[63:56];
      4'd8:    b = e[71:64];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pool_lin_sender_snap_fifo.sv
// Synchronous snapshot FIFO; exposes the head and the entry behind it so the
// serializer can chain rows without a bubble. DEPTH must be a power of two.
module pool_lin_sender_snap_fifo
  import pool_lin_sender_pkg::*;
#(
  parameter int WIDTH = SNAP_W,
  parameter int DEPTH = BUF_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] nxt,
  output logic             full,
  output logic             empty,
  output logic             has_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2'd2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    nxt_ptr_s;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop_s  = pop && (count_r != '0);
  assign do_push_s = push && ((count_r != CNT_FULL) || do_pop_s);
  assign nxt_ptr_s = rd_ptr_r + PTR_ONE;

  assign head     = mem[rd_ptr_r];
  assign nxt      = mem[nxt_ptr_s];
  assign full     = (count_r == CNT_FULL);
  assign empty    = (count_r == '0);
  assign has_next = (count_r >= CNT_TWO);

  // Storage array; no reset needed, occupancy is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= nxt_ptr_s;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pool_lin_sender.sv
// Snapshots the three pooled line vectors at fixed controller counts and
// streams them byte-by-byte to the FC layer, tagging the end of each frame.
module pool_lin_sender
  import pool_lin_sender_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int CAP0      = CAP0_DEF,
  parameter int CAP1      = CAP1_DEF,
  parameter int CAP2      = CAP2_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [CNT_W-1:0] cnt,
  input  logic [23:0]      pool_lin_D1,
  input  logic [23:0]      pool_lin_D2,
  input  logic [23:0]      pool_lin_D3,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [7:0]       out_data,
  output logic [1:0]       out_row,
  output logic             out_last,
  output logic             busy,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CAP0_C   = CNT_W'(CAP0);
  localparam logic [CNT_W-1:0] CAP1_C   = CNT_W'(CAP1);
  localparam logic [CNT_W-1:0] CAP2_C   = CNT_W'(CAP2);
  localparam logic [CNT_W-1:0] CNT_MAXC = CNT_W'(CNT_MAX);
  localparam logic [IDX_W-1:0] IDX_ZERO = 4'd0;
  localparam logic [IDX_W-1:0] IDX_ONE  = 4'd1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(POOL_BYTES - 1);
  localparam logic [1:0]       ROW_LAST = 2'd2;

  ser_state_t       state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s, idx_inc_s;
  logic [7:0]       out_data_r, data_nxt_s;
  logic [1:0]       out_row_r, row_nxt_s;
  logic             out_last_r, last_nxt_s;
  logic             ovf_r;

  logic             cnt_ok_s, hit0_s, hit1_s, hit2_s, cap_s;
  logic [1:0]       cap_tag_s;
  snap_t            wr_entry_s, head_s, nxt_s, load_entry_s;
  logic             full_s, empty_s, has_next_s;
  logic             pop_s, avail_s, ovf_set_s, frame_start_s;
  logic [7:0]       first_byte_s, step_byte_s;

  assign cnt_ok_s      = (cnt <= CNT_MAXC);
  assign hit0_s        = in_vld && cnt_ok_s && (cnt == CAP0_C);
  assign hit1_s        = in_vld && cnt_ok_s && (cnt == CAP1_C);
  assign hit2_s        = in_vld && cnt_ok_s && (cnt == CAP2_C);
  assign cap_s         = hit0_s || hit1_s || hit2_s;
  assign frame_start_s = in_vld && (cnt == '0);

  // Row tag comes from which capture point matched.
  always_comb begin
    cap_tag_s = 2'd0;
    if (hit2_s) begin
      cap_tag_s = 2'd2;
    end else if (hit1_s) begin
      cap_tag_s = 2'd1;
    end else begin
      cap_tag_s = 2'd0;
    end
  end

  assign wr_entry_s.tag  = cap_tag_s;
  assign wr_entry_s.data = {pool_lin_D3, pool_lin_D2, pool_lin_D1};

  pool_lin_sender_snap_fifo #(
    .WIDTH (SNAP_W),
    .DEPTH (BUF_DEPTH)
  ) u_snap_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cap_s),
    .pop      (pop_s),
    .wdata    (wr_entry_s),
    .head     (head_s),
    .nxt      (nxt_s),
    .full     (full_s),
    .empty    (empty_s),
    .has_next (has_next_s)
  );

  // Source of the next row: a capture arriving when nothing else is queued is
  // forwarded directly so its first byte appears the cycle after capture.
  always_comb begin
    load_entry_s = head_s;
    avail_s      = 1'b0;
    if (state_r == ST_SEND) begin
      load_entry_s = has_next_s ? nxt_s : wr_entry_s;
      avail_s      = has_next_s || cap_s;
    end else begin
      load_entry_s = empty_s ? wr_entry_s : head_s;
      avail_s      = (!empty_s) || cap_s;
    end
  end

  assign idx_inc_s    = idx_r + IDX_ONE;
  assign first_byte_s = entry_byte(load_entry_s.data, IDX_ZERO);
  assign step_byte_s  = entry_byte(head_s.data, idx_inc_s);

  // Serializer next-state and next output values.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    data_nxt_s  = out_data_r;
    row_nxt_s   = out_row_r;
    last_nxt_s  = out_last_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (avail_s) begin
          state_nxt_s = ST_SEND;
          idx_nxt_s   = IDX_ZERO;
          data_nxt_s  = first_byte_s;
          row_nxt_s   = load_entry_s.tag;
          last_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (out_rdy && (idx_r == IDX_LAST)) begin
          pop_s = 1'b1;
          if (avail_s) begin
            idx_nxt_s  = IDX_ZERO;
            data_nxt_s = first_byte_s;
            row_nxt_s  = load_entry_s.tag;
            last_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = IDX_ZERO;
            data_nxt_s  = 8'h00;
            row_nxt_s   = 2'd0;
            last_nxt_s  = 1'b0;
          end
        end else if (out_rdy) begin
          idx_nxt_s  = idx_inc_s;
          data_nxt_s = step_byte_s;
          last_nxt_s = (idx_inc_s == IDX_LAST) && (out_row_r == ROW_LAST);
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = IDX_ZERO;
        data_nxt_s  = 8'h00;
        row_nxt_s   = 2'd0;
        last_nxt_s  = 1'b0;
      end
    endcase
  end

  // Serializer state and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= IDX_ZERO;
      out_data_r <= 8'h00;
      out_row_r  <= 2'd0;
      out_last_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      out_data_r <= data_nxt_s;
      out_row_r  <= row_nxt_s;
      out_last_r <= last_nxt_s;
    end
  end

  // A capture is lost only when the FIFO is full and no pop frees a slot.
  assign ovf_set_s = cap_s && full_s && !pop_s;

  // Sticky overflow, cleared at frame start; a concurrent set takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (frame_start_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign out_vld  = (state_r == ST_SEND);
  assign out_data = out_data_r;
  assign out_row  = out_row_r;
  assign out_last = out_last_r;
  assign busy     = (!empty_s) || (state_r == ST_SEND);
  assign ovf      = ovf_r;

endmodule
